// File: rtl/matrix_operand_loader_pkg.sv
// Shared operand-memory definitions: loader states, default sizes and the
// row-major element address used by the loader and the datapath address calculators.
package mm_pkg;

  localparam int MM_DATA_WIDTH = 3;
  localparam int MM_DIM        = 3;
  localparam int MM_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [15:0] addr_calc_t;

  function automatic addr_calc_t elem_addr(input addr_calc_t row, input addr_calc_t col,
                                           input int dim);
    return addr_calc_t'(int'(row) * dim + int'(col));
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Element stream in, A/B memory write port out. The slave modport is the loader,
// and the master modport is the stream source and memory side.
interface matrix_operand_loader_if #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  write_en_a;
  logic                  write_en_b;
  logic [ADDR_WIDTH-1:0] address_out;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output in_data, in_valid,
    input  in_ready, write_en_a, write_en_b, address_out, data_out
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_en_a, write_en_b, address_out, data_out
  );
endinterface

// File: rtl/matrix_index_counter.sv
// Row/col walker over a DIM x DIM matrix: advances on en, wraps col into row,
// and wraps both to zero after the last element.
module matrix_index_counter #(
  parameter int DIM   = 3,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] row,
  output logic [WIDTH-1:0] col,
  output logic             last
);
  localparam logic [WIDTH-1:0] MAX_IDX = WIDTH'(DIM - 1);

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/matrix_operand_loader.sv
// Writes a streamed matrix A then matrix B into the operand memories.
// Optional LOADER_CHECKSUM_EN adds an 8-bit running sum of accepted elements.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LOAD_A | accepting A elements, strobing write_en_a
//   LOAD_B | accepting B elements, strobing write_en_b
//   DONE   | both matrices written, load_done held until next start
module matrix_operand_loader
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int DIM        = MM_DIM,
  parameter int ADDR_WIDTH = MM_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  matrix_operand_loader_if.slave  bus,
  output logic                    busy,
  output logic                    load_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]              checksum
`endif
);
  state_t                state;
  logic                  xfer;
  logic                  start_ok;
  logic                  last;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  assign cur_addr     = ADDR_WIDTH'(elem_addr(addr_calc_t'(row), addr_calc_t'(col), DIM));

  matrix_index_counter #(
    .DIM   (DIM),
    .WIDTH (ADDR_WIDTH)
  ) u_index (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .clr   (start_ok),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.write_en_a  <= 1'b0;
      bus.write_en_b  <= 1'b0;
      bus.address_out <= '0;
      bus.data_out    <= '0;
      busy            <= 1'b0;
      load_done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum        <= 8'd0;
`endif
    end else begin
      bus.write_en_a <= 1'b0;
      bus.write_en_b <= 1'b0;
      if (xfer) begin
        bus.address_out <= cur_addr;
        bus.data_out    <= DATA_WIDTH'(bus.in_data);
      end
`ifdef LOADER_CHECKSUM_EN
      if (start_ok)  checksum <= 8'd0;
      else if (xfer) checksum <= checksum + 8'(bus.in_data);
`endif
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= LOAD_A;
            busy      <= 1'b1;
            load_done <= 1'b0;
          end
        end
        LOAD_A: begin
          if (xfer) begin
            bus.write_en_a <= 1'b1;
            // last A element hands straight over to B with no idle cycle
            if (last) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            bus.write_en_b <= 1'b1;
            if (last) begin
              state     <= DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader; define LOADER_CHECKSUM_EN to cover the checksum port.
module tb_matrix_operand_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, load_done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  matrix_operand_loader_if #(.DATA_WIDTH(3), .ADDR_WIDTH(4)) bus ();

  matrix_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .load_done (load_done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_b;
    logic [3:0] addr;
    logic [2:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;

  // reference model: 0 idle, 1 load A, 2 load B, 3 done
  int         m_state = 0;
  int         m_idx = 0;
  logic [7:0] m_sum = 8'd0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (bus.write_en_a === 1'b1 || bus.write_en_b === 1'b1)) begin
      strobes++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got we_a=%b we_b=%b addr=%0d want no strobe",
                 bus.write_en_a, bus.write_en_b, bus.address_out);
      end else begin
        e = sb.pop_front();
        if (bus.write_en_a !== !e.is_b || bus.write_en_b !== e.is_b ||
            bus.address_out !== e.addr || bus.data_out !== e.data) begin
          bad++;
          $display("FAIL write: got we_a=%b we_b=%b addr=%0d data=%0d want we_a=%b we_b=%b addr=%0d data=%0d",
                   bus.write_en_a, bus.write_en_b, bus.address_out, bus.data_out,
                   !e.is_b, e.is_b, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic [2:0] d);
    logic exp_ready;
    exp_t e;
    start = s;
    bus.in_valid = v;
    bus.in_data = d;
    exp_ready = (m_state == 1 || m_state == 2);
    total++;
    if (bus.in_ready !== exp_ready) begin
      bad++;
      $display("FAIL in_ready: got %b want %b", bus.in_ready, exp_ready);
    end
    if (exp_ready && v) begin
      e.is_b = (m_state == 2);
      e.addr = 4'(m_idx);
      e.data = d;
      sb.push_back(e);
      m_sum = m_sum + 8'(d);
      m_idx++;
      if (m_idx == 9) begin
        m_idx = 0;
        m_state = (m_state == 1) ? 2 : 3;
      end
    end else if (s && (m_state == 0 || m_state == 3)) begin
      m_state = 1;
      m_idx = 0;
      m_sum = 8'd0;
    end
    @(negedge clk);
    total++;
    if (busy !== (m_state == 1 || m_state == 2) || load_done !== (m_state == 3)) begin
      bad++;
      $display("FAIL status: got busy=%b load_done=%b want busy=%b load_done=%b",
               busy, load_done, (m_state == 1 || m_state == 2), (m_state == 3));
    end
`ifdef LOADER_CHECKSUM_EN
    total++;
    if (checksum !== m_sum) begin
      bad++;
      $display("FAIL checksum_track: got %0d want %0d", checksum, m_sum);
    end
`endif
  endtask

  task automatic flush(input string name);
    drive(0, 0, 3'd0);
    drive(0, 0, 3'd0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus.in_ready !== 1'b0 || bus.write_en_a !== 1'b0 || bus.write_en_b !== 1'b0 ||
        bus.address_out !== 4'd0 || bus.data_out !== 3'd0 || busy !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL %s: got rdy=%b wa=%b wb=%b addr=%0d data=%0d busy=%b done=%b want all 0",
               name, bus.in_ready, bus.write_en_a, bus.write_en_b, bus.address_out,
               bus.data_out, busy, load_done);
    end
`ifdef LOADER_CHECKSUM_EN
    total++;
    if (checksum !== 8'd0) begin
      bad++;
      $display("FAIL %s_checksum: got %0d want 0", name, checksum);
    end
`endif
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data = 3'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // valid while idle must be ignored
    drive(0, 1, 3'd5);
    drive(0, 1, 3'd6);
    flush("idle_valid");
  endtask

  task automatic test_back_to_back();
    int s0;
    drive(1, 0, 3'd0);
    s0 = strobes;
    for (int i = 0; i < 9; i++) drive(0, 1, (i == 8) ? 3'd0 : 3'(i));
    for (int i = 0; i < 9; i++) drive(0, 1, (i == 8) ? 3'd7 : 3'(7 - i));
    drive(0, 0, 3'd0);
    total++;
    if (strobes - s0 != 18) begin
      bad++;
      $display("FAIL b2b_strobe_count: got %0d want 18", strobes - s0);
    end
    flush("b2b");
  endtask

  task automatic test_done_ignores_valid();
    int s0;
    s0 = strobes;
    drive(0, 1, 3'd2);
    drive(0, 1, 3'd4);
    drive(0, 1, 3'd1);
    total++;
    if (strobes != s0) begin
      bad++;
      $display("FAIL done_valid_strobes: got %0d want 0", strobes - s0);
    end
    flush("done_valid");
  endtask

  task automatic test_toggle_valid();
    drive(1, 0, 3'd0);
    for (int i = 0; i < 36; i++) drive(0, (i % 2 == 0), 3'($urandom_range(0, 7)));
    flush("toggle");
  endtask

  task automatic test_restart();
    drive(1, 0, 3'd0);
    drive(0, 1, 3'd3);
    for (int i = 0; i < 17; i++) drive(0, 1, 3'($urandom_range(0, 7)));
    flush("restart");
  endtask

  task automatic test_start_in_load_b();
    drive(1, 0, 3'd0);
    for (int i = 0; i < 11; i++) drive(0, 1, 3'(i));
    drive(1, 1, 3'd6);
    drive(1, 0, 3'd0);
    for (int i = 0; i < 6; i++) drive(0, 1, 3'(i + 1));
    flush("start_in_b");
  endtask

  task automatic test_reset_mid_load();
    drive(1, 0, 3'd0);
    for (int i = 0; i < 4; i++) drive(0, 1, 3'(i + 2));
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    sb.delete();
    m_state = 0;
    m_idx = 0;
    m_sum = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 3'd1);
    drive(1, 0, 3'd0);
    drive(0, 1, 3'd5);
    for (int i = 0; i < 17; i++) drive(0, 1, 3'($urandom_range(0, 7)));
    flush("reset_mid_reload");
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    drive(1, 0, 3'd0);
    for (int i = 0; i < 18; i++) drive(0, 1, 3'd7);
    total++;
    if (checksum !== 8'd126) begin
      bad++;
      $display("FAIL checksum_full: got %0d want 126", checksum);
    end
    drive(1, 0, 3'd0);
    total++;
    if (checksum !== 8'd0) begin
      bad++;
      $display("FAIL checksum_clear: got %0d want 0", checksum);
    end
    for (int i = 0; i < 18; i++) drive(0, 1, 3'd7);
    flush("checksum");
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_done_ignores_valid();
    test_toggle_valid();
    test_restart();
    test_start_in_load_b();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
